// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline sequencer: run-control states
// and the stage numbering of the default six-stage configuration.
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

  localparam int unsigned DEFAULT_NUM_STAGES = 6;

  localparam int unsigned STG_FETCH_REQ  = 0;
  localparam int unsigned STG_FETCH_WAIT = 1;
  localparam int unsigned STG_DECODE     = 2;
  localparam int unsigned STG_SETUP      = 3;
  localparam int unsigned STG_EXECUTE    = 4;
  localparam int unsigned STG_WRITEBACK  = 5;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control FSM that steps a one-hot stage strobe through NUM_STAGES stages,
// with per-stage stall, global freeze, flush, halt-after-retire and counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  enable,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush,
  input  logic                  halt_req,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  stage_enter,
  output logic                  retire,
  output logic                  running,
  output logic                  halted,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      retired_count
);

  localparam logic [IDX_W-1:0] IDX0 = IDX_W'(STG_FETCH_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STAGES - 1);

  seq_state_e       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_enter;
  logic             r_halt_pending;

  logic w_running;
  logic w_advance;
  logic w_flush;
  logic w_retire;

  assign w_running = (r_state == ST_RUN);
  assign w_advance = enable & ~stall_req[r_idx] & ~flush;
  assign w_flush   = w_running & enable & flush;
  assign w_retire  = w_running & (r_idx == LAST) & w_advance;

  // r_idx is forced to stage 0 whenever the FSM leaves RUN, so it can drive
  // stage_idx directly without an extra gate.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= IDX0;
      r_enter        <= 1'b0;
      r_halt_pending <= 1'b0;
    end else begin
      r_enter <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            r_state <= ST_RUN;
            r_idx   <= IDX0;
            r_enter <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_flush) begin
            r_idx   <= IDX0;
            r_enter <= 1'b1;
          end else if (w_advance) begin
            r_idx   <= (r_idx == LAST) ? IDX0 : r_idx + IDX_W'(1);
            r_enter <= 1'b1;
          end
          // A halt_req coinciding with a non-halting retire arms the next one.
          if (w_retire && r_halt_pending) begin
            r_state        <= ST_HALTED;
            r_idx          <= IDX0;
            r_enter        <= 1'b0;
            r_halt_pending <= 1'b0;
          end else if (halt_req) begin
            r_halt_pending <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= IDX0;
        end
      endcase
    end
  end

  assign stage_onehot = w_running ? (NUM_STAGES'(1) << r_idx) : '0;
  assign stage_idx    = r_idx;
  assign stage_enter  = r_enter;
  assign retire       = w_retire;
  assign running      = w_running;
  assign halted       = (r_state == ST_HALTED);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_running),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_retire),
    .q     (retired_count)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench: stimulus pushes hand-derived expected outputs per cycle,
// a negedge monitor pops and compares against the selected DUT instance.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, enable, flush, halt_req;
  logic [5:0]  stall6;
  logic [1:0]  stall2;
  logic [8:0]  stall9;

  logic [5:0]  oh6;  logic [2:0] idx6; logic ent6, ret6, run6, hlt6;
  logic [31:0] cc6, rc6;
  logic [1:0]  oh2;  logic [0:0] idx2; logic ent2, ret2, run2, hlt2;
  logic [3:0]  cc2, rc2;
  logic [8:0]  oh9;  logic [3:0] idx9; logic ent9, ret9, run9, hlt9;
  logic [3:0]  cc9, rc9;

  always #5 clk = ~clk;

  pipeline_sequencer #(.NUM_STAGES(6), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .stall_req(stall6),
    .flush(flush), .halt_req(halt_req), .stage_onehot(oh6), .stage_idx(idx6),
    .stage_enter(ent6), .retire(ret6), .running(run6), .halted(hlt6),
    .cycle_count(cc6), .retired_count(rc6));

  pipeline_sequencer #(.NUM_STAGES(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .stall_req(stall2),
    .flush(flush), .halt_req(halt_req), .stage_onehot(oh2), .stage_idx(idx2),
    .stage_enter(ent2), .retire(ret2), .running(run2), .halted(hlt2),
    .cycle_count(cc2), .retired_count(rc2));

  pipeline_sequencer #(.NUM_STAGES(9), .CNT_W(4)) dut9 (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .stall_req(stall9),
    .flush(flush), .halt_req(halt_req), .stage_onehot(oh9), .stage_idx(idx9),
    .stage_enter(ent9), .retire(ret9), .running(run9), .halted(hlt9),
    .cycle_count(cc9), .retired_count(rc9));

  typedef struct {
    int          dut;
    string       nm;
    logic [15:0] oh;
    logic [31:0] idx;
    logic        ent, ret, run, hlt;
    logic [31:0] cc, rc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  exp_t        m_e;
  logic [15:0] a_oh;
  logic [31:0] a_idx, a_cc, a_rc;
  logic        a_ent, a_ret, a_run, a_hlt;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      case (m_e.dut)
        1: begin
          a_oh = {14'b0, oh2}; a_idx = {31'b0, idx2}; a_ent = ent2; a_ret = ret2;
          a_run = run2; a_hlt = hlt2; a_cc = {28'b0, cc2}; a_rc = {28'b0, rc2};
        end
        2: begin
          a_oh = {7'b0, oh9}; a_idx = {28'b0, idx9}; a_ent = ent9; a_ret = ret9;
          a_run = run9; a_hlt = hlt9; a_cc = {28'b0, cc9}; a_rc = {28'b0, rc9};
        end
        default: begin
          a_oh = {10'b0, oh6}; a_idx = {29'b0, idx6}; a_ent = ent6; a_ret = ret6;
          a_run = run6; a_hlt = hlt6; a_cc = cc6; a_rc = rc6;
        end
      endcase
      tests++;
      if (a_oh !== m_e.oh || a_idx !== m_e.idx || a_ent !== m_e.ent || a_ret !== m_e.ret ||
          a_run !== m_e.run || a_hlt !== m_e.hlt || a_cc !== m_e.cc || a_rc !== m_e.rc) begin
        fails++;
        $display("FAIL %s: got oh=%h idx=%0d ent=%b ret=%b run=%b hlt=%b cc=%0d rc=%0d; expected oh=%h idx=%0d ent=%b ret=%b run=%b hlt=%b cc=%0d rc=%0d",
                 m_e.nm, a_oh, a_idx, a_ent, a_ret, a_run, a_hlt, a_cc, a_rc,
                 m_e.oh, m_e.idx, m_e.ent, m_e.ret, m_e.run, m_e.hlt, m_e.cc, m_e.rc);
      end
    end
  end

  task automatic step(input int d, input string nm, input bit st, input bit en,
                      input bit fl, input bit hr, input logic [15:0] stl,
                      input int idx, input bit run, input bit hlt, input bit ent,
                      input bit ret, input int cc, input int rc);
    exp_t e;
    start    = st;
    enable   = en;
    flush    = fl;
    halt_req = hr;
    stall6   = stl[5:0];
    stall2   = stl[1:0];
    stall9   = stl[8:0];
    e.dut = d;   e.nm = nm;
    e.idx = idx; e.oh = run ? (16'h1 << idx) : 16'h0;
    e.ent = ent; e.ret = ret; e.run = run; e.hlt = hlt;
    e.cc  = cc;  e.rc  = rc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; enable = 1'b1; flush = 1'b0; halt_req = 1'b0;
    stall6 = '0; stall2 = '0; stall9 = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    step(0, "reset_state", 0, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(0, "idle",        0, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    step(0, "start",       1, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      step(0, "walk", 0, 1, 0, 0, 16'h0, i % 6, 1, 0, 1, (i % 6) == 5, i, i / 6);

    // stall in stage 4 for three cycles; stall bit 5 while stage 2 is don't-care
    for (int i = 0; i < 4; i++)
      step(0, "pre_stall", 0, 1, 0, 0, (i == 2) ? 16'h0020 : 16'h0, i, 1, 0, 1, 0, 12 + i, 2);
    step(0, "stall4_a",   0, 1, 0, 0, 16'h0010, 4, 1, 0, 1, 0, 16, 2);
    step(0, "stall4_b",   0, 1, 0, 0, 16'h0010, 4, 1, 0, 0, 0, 17, 2);
    step(0, "stall4_c",   0, 1, 0, 0, 16'h0010, 4, 1, 0, 0, 0, 18, 2);
    step(0, "stall4_rel", 0, 1, 0, 0, 16'h0000, 4, 1, 0, 0, 0, 19, 2);
    step(0, "late_retire",0, 1, 0, 0, 16'h0000, 5, 1, 0, 1, 1, 20, 2);

    for (int i = 0; i < 3; i++)
      step(0, "pre_flush", 0, 1, 0, 0, 16'h0, i, 1, 0, 1, 0, 21 + i, 3);
    step(0, "flush_s3",    0, 1, 1, 0, 16'h0008, 3, 1, 0, 1, 0, 24, 3);
    step(0, "after_flush", 0, 1, 0, 0, 16'h0,    0, 1, 0, 1, 0, 25, 3);
    for (int i = 1; i < 5; i++)
      step(0, "walk_f", 0, 1, 0, 0, 16'h0, i, 1, 0, 1, 0, 25 + i, 3);
    step(0, "flush_last",  0, 1, 1, 0, 16'h0, 5, 1, 0, 1, 0, 30, 3);
    step(0, "after_flush5",0, 1, 0, 0, 16'h0, 0, 1, 0, 1, 0, 31, 3);

    step(0, "halt_req_s1", 0, 1, 0, 1, 16'h0, 1, 1, 0, 1, 0, 32, 3);
    for (int i = 2; i < 5; i++)
      step(0, "walk_h", 0, 1, 0, 0, 16'h0, i, 1, 0, 1, 0, 31 + i, 3);
    step(0, "halt_retire", 0, 1, 0, 0, 16'h0, 5, 1, 0, 1, 1, 36, 3);
    step(0, "halted",      0, 1, 1, 1, 16'h0, 0, 0, 1, 0, 0, 37, 4);
    step(0, "halted_hold", 0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0, 37, 4);
    step(0, "restart",     1, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0, 37, 4);
    step(0, "resume",      0, 1, 0, 0, 16'h0, 0, 1, 0, 1, 0, 37, 4);
    for (int i = 1; i < 5; i++)
      step(0, "walk_r", 0, 1, 0, 0, 16'h0, i, 1, 0, 1, 0, 37 + i, 4);
    step(0, "halt_at_retire", 0, 1, 0, 1, 16'h0, 5, 1, 0, 1, 1, 42, 4);
    step(0, "pending_kept",   0, 1, 0, 0, 16'h0, 0, 1, 0, 1, 0, 43, 5);
    for (int i = 1; i < 5; i++)
      step(0, "walk_p", 0, 1, 0, 0, 16'h0, i, 1, 0, 1, 0, 43 + i, 5);
    step(0, "deferred_halt",  0, 1, 0, 0, 16'h0, 5, 1, 0, 1, 1, 48, 5);
    step(0, "halted2",        0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0, 49, 6);
    step(0, "restart2",       1, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0, 49, 6);
    step(0, "run_s0",         0, 1, 0, 0, 16'h0, 0, 1, 0, 1, 0, 49, 6);
    step(0, "run_s1",         0, 1, 0, 0, 16'h0, 1, 1, 0, 1, 0, 50, 6);

    // freeze for five cycles in stage 2 with flush asserted inside the freeze
    for (int i = 0; i < 5; i++)
      step(0, "freeze", 0, 0, (i == 1) || (i == 2), 0, 16'h0, 2, 1, 0, i == 0, 0, 51 + i, 6);
    step(0, "unfreeze", 0, 1, 0, 0, 16'h0, 2, 1, 0, 0, 0, 56, 6);
    reset = 1'b1;
    step(0, "reset_mid",   1, 1, 1, 1, 16'h003F, 3, 1, 0, 1, 0, 57, 6);
    reset = 1'b0;
    step(0, "after_reset", 0, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
    reset = 1'b0;
    step(1, "n2_start", 1, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++)
      step(1, "n2_walk", 0, 1, 0, 0, 16'h0, i % 2, 1, 0, 1, (i % 2) == 1,
           (i > 15) ? 15 : i, ((i / 2) > 15) ? 15 : i / 2);

    do_reset();
    reset = 1'b0;
    step(2, "n9_start", 1, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 153; i++)
      step(2, "n9_walk", 0, 1, 0, 0, 16'h0, i % 9, 1, 0, 1, (i % 9) == 8,
           (i > 15) ? 15 : i, ((i / 9) > 15) ? 15 : i / 9);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
